pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
//
// PURPOSE
// - Parametrised, generic pipeline-stage register. Next generation of the per-stage EX/DF-style latches.
// - Replaces the STALL-vector hold/bubble scheme with a valid/ready handshake and a 2-entry skid buffer.
//   READY is fully registered, so back-pressure does not form a combinational path across stages.
// - Payload is an opaque DATA_W bundle: ALU op, GPR we/waddr/wdata, SRAM byte enables, packed by the instantiator.
//
// PARAMETERS
// - DATA_W   48    payload width in bits (>=1)
// - NOP_VAL  '0    payload driven on DN_DATA whenever DN_VALID=0, e.g. the packed EXE_NOP_OP / ~WE bundle
// - CNT_W    16    perf counter width; used only with PIPE_STAGE_PERF_EN
//
// PORTS
// - CLK         in   1       clock, rising edge
// - RST         in   1       asynchronous, active-low reset
// - FLUSH       in   1       synchronous kill of all held beats
// - UP_VALID    in   1       upstream beat valid
// - UP_READY    out  1       stage can accept a beat this cycle (registered)
// - UP_DATA     in   DATA_W  upstream payload
// - DN_VALID    out  1       downstream beat valid (registered)
// - DN_READY    in   1       downstream accepts DN_DATA this cycle
// - DN_DATA     out  DATA_W  downstream payload; NOP_VAL when DN_VALID=0
// - OCC         out  2       entries held: 0, 1 or 2
// - STALL_CNT   out  CNT_W   (PIPE_STAGE_PERF_EN only) cycles with DN_VALID & ~DN_READY
// - BUBBLE_CNT  out  CNT_W   (PIPE_STAGE_PERF_EN only) cycles with ~DN_VALID & DN_READY
//
// BEHAVIOUR
// - Storage: main register M (drives DN_*) and skid register S. State is encoded by OCC.
//   EMPTY (0): M and S invalid.  ONE (1): M valid.  FULL (2): M and S valid.
// - Handshakes:
//   - Upstream accept: up_acc = UP_VALID & UP_READY.
//   - Downstream accept: dn_acc = DN_VALID & DN_READY.
//   - UP_READY = (OCC != 2), held in a register.
// - Transitions (no FLUSH):
//   - EMPTY, up_acc -> ONE; M <= UP_DATA.
//   - ONE, up_acc & ~dn_acc -> FULL; S <= UP_DATA.
//   - ONE, up_acc & dn_acc -> ONE; M <= UP_DATA.
//   - ONE, ~up_acc & dn_acc -> EMPTY.
//   - FULL, dn_acc -> ONE; M <= S. No upstream accept is possible because UP_READY=0.
//   - All other cases hold state and data.
// - Latency and throughput:
//   - 1 cycle, UP_DATA to DN_DATA, when EMPTY or when ONE with dn_acc.
//   - Full throughput of 1 beat/cycle with DN_READY held high. Beats leave strictly in arrival order.
// - DN_VALID must not drop, and DN_DATA must not change, while DN_VALID & ~DN_READY. Only a FLUSH may break this.
// - FLUSH:
//   - Next cycle OCC=0, DN_VALID=0, DN_DATA=NOP_VAL, UP_READY=1.
//   - A beat offered in the same cycle is dropped: FLUSH wins over up_acc.
//   - dn_acc in the FLUSH cycle still counts as consumed downstream.
// - Reset (RST=0, async):
//   - OCC=0, DN_VALID=0, DN_DATA=NOP_VAL, UP_READY=1, counters=0.
//   - UP_VALID is ignored while RST=0.
//   - Reset mid-FULL discards both beats with no partial state.
//   - First accept is possible on the first rising edge after RST releases.
// - S contents are don't-care when S is invalid and are never visible on DN_DATA.
//
// CONFIGURATION
// - PIPE_STAGE_PERF_EN defined:
//   - STALL_CNT and BUBBLE_CNT ports exist. Each increments by 1 per qualifying cycle.
//   - Counters saturate at 2^CNT_W-1, clear on reset, and are not cleared by FLUSH.
// - PIPE_STAGE_PERF_EN undefined:
//   - Both ports and all counter logic are absent. Handshake behaviour is identical.
//
// TESTING
// 1. Reset then stream:
//    - Stimulus: RST low 3 cycles, release; UP_VALID=1 with data 1..8 on consecutive cycles, DN_READY=1.
//    - Required: DN_VALID from cycle 1, DN_DATA 1..8 on consecutive cycles, OCC=1 throughout, UP_READY=1.
// 2. Back-pressure:
//    - Stimulus: stream A,B,C; DN_READY=0 from the cycle A appears on DN_DATA.
//    - Required: OCC=2 holding A,B; UP_READY=0; C held upstream.
//    - Then DN_READY=1: DN_DATA = A, B, C on consecutive cycles with no loss or duplication.
// 3. Flush in FULL:
//    - Stimulus: OCC=2 holding 0x11,0x22; FLUSH=1 with UP_VALID=1, data 0x33.
//    - Required: next cycle OCC=0, DN_VALID=0, DN_DATA=NOP_VAL, UP_READY=1; 0x33 never appears.
// 4. Async reset mid-operation:
//    - Stimulus: OCC=2; drop RST between clock edges.
//    - Required: DN_VALID=0 and OCC=0 immediately, before the next edge; counters=0.
// 5. Random handshake:
//    - Stimulus: 10,000 cycles of random UP_VALID/DN_READY with a scoreboard.
//    - Required: in-order, lossless delivery; DN_DATA stable while stalled; OCC<=2.
// 6. PIPE_STAGE_PERF_EN build:
//    - Stimulus: 5 cycles DN_VALID=1/DN_READY=0, then 3 cycles empty with DN_READY=1.
//    - Required: STALL_CNT=5, BUBBLE_CNT=3.
//    - With CNT_W=2, 10 stall cycles give STALL_CNT=3 (saturated).

Source files
------------

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic pipeline-stage register with a valid/ready handshake and a 2-entry
// skid buffer. The stage holds up to two beats:
//   M - main register. It drives o_dn_data. It holds NOP_VAL while no beat is present.
//   S - skid register. It catches the beat accepted in the same cycle that the
//       downstream stalls. It is never visible on o_dn_data.
// o_up_ready and o_dn_valid come directly from flops. Back-pressure therefore
// does not form a combinational path from i_dn_ready to o_up_ready.
//
// Handshake rule: a beat moves across an interface on a rising edge where
// valid and ready are both high. A producer that raises valid keeps valid and
// data stable until that edge. This stage keeps that promise on the
// downstream side; only i_flush or reset may withdraw a presented beat.
//
// Optional build macro: PIPE_STAGE_PERF_EN adds saturating stall and bubble
// counters (o_stall_cnt, o_bubble_cnt).
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_flush        synchronous kill of all held beats (wins over an upstream accept)
//   i_up_valid     upstream beat valid
//   o_up_ready     stage can accept a beat (registered, = occupancy != 2)
//   i_up_data      upstream payload
//   o_dn_valid     downstream beat valid (registered)
//   i_dn_ready     downstream accepts o_dn_data
//   o_dn_data      downstream payload, NOP_VAL when o_dn_valid = 0
//   o_occ          entries held (0, 1, 2); also the FSM state
//   o_stall_cnt    (PIPE_STAGE_PERF_EN) cycles with o_dn_valid & ~i_dn_ready
//   o_bubble_cnt   (PIPE_STAGE_PERF_EN) cycles with ~o_dn_valid & i_dn_ready
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                DATA_W  = 48,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_up_valid,
    output logic              o_up_ready,
    input  logic [DATA_W-1:0] i_up_data,
    output logic              o_dn_valid,
    input  logic              i_dn_ready,
    output logic [DATA_W-1:0] o_dn_data,
    output logic [1:0]        o_occ
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_bubble_cnt
`endif
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_m_data;
    logic [DATA_W-1:0] r_s_data;
    logic              r_up_ready;
    logic              r_dn_valid;

    logic              w_up_acc;
    logic              w_dn_acc;
    logic [1:0]        w_occ_nxt;
    logic [DATA_W-1:0] w_m_nxt;
    logic [DATA_W-1:0] w_s_nxt;

    assign w_up_acc = i_up_valid & r_up_ready;
    assign w_dn_acc = r_dn_valid & i_dn_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        w_m_nxt   = r_m_data;
        w_s_nxt   = r_s_data;
        if (i_flush) begin
            // Any downstream accept in this cycle has already happened.
            // Every beat still held is dropped, and so is any beat offered now.
            w_occ_nxt = OCC_EMPTY;
            w_m_nxt   = NOP_VAL;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_up_acc) begin
                        w_occ_nxt = OCC_ONE;
                        w_m_nxt   = i_up_data;
                    end
                end
                OCC_ONE: begin
                    if (w_up_acc && !w_dn_acc) begin
                        w_occ_nxt = OCC_FULL;
                        w_s_nxt   = i_up_data;
                    end else if (w_up_acc && w_dn_acc) begin
                        w_m_nxt   = i_up_data;
                    end else if (w_dn_acc) begin
                        w_occ_nxt = OCC_EMPTY;
                        w_m_nxt   = NOP_VAL;
                    end
                end
                OCC_FULL: begin
                    // o_up_ready is low here, so only the downstream side can move.
                    if (w_dn_acc) begin
                        w_occ_nxt = OCC_ONE;
                        w_m_nxt   = r_s_data;
                    end
                end
                default: begin
                    w_occ_nxt = OCC_EMPTY;
                    w_m_nxt   = NOP_VAL;
                end
            endcase
        end
    end

    // The ready and valid flops are loaded from the next occupancy.
    // Both outputs are then already correct in the cycle after any transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ      <= OCC_EMPTY;
            r_m_data   <= NOP_VAL;
            r_s_data   <= '0;
            r_up_ready <= 1'b1;
            r_dn_valid <= 1'b0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_m_data   <= w_m_nxt;
            r_s_data   <= w_s_nxt;
            r_up_ready <= (w_occ_nxt != OCC_FULL);
            r_dn_valid <= (w_occ_nxt != OCC_EMPTY);
        end
    end

    assign o_up_ready = r_up_ready;
    assign o_dn_valid = r_dn_valid;
    assign o_dn_data  = r_m_data;
    assign o_occ      = r_occ;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // The counters saturate at all-ones. They survive a flush and clear only on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_dn_valid && !i_dn_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!r_dn_valid && i_dn_ready && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam logic [DW-1:0] NOP = 16'hDEAD;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [DW-1:0] up_data = '0;
  logic          dn_valid;
  logic          dn_ready = 1'b0;
  logic [DW-1:0] dn_data;
  logic [1:0]    occ;

  int n_checks = 0;
  int n_fail = 0;
  int n_beats = 0;

  // reference model: the queue holds the beats inside the stage, oldest first
  logic [DW-1:0] exp_q[$];
  int            sz;
  bit            cap;
  logic [DW-1:0] got;
  int            m_stall = 0;
  int            m_bubble = 0;
  int            m_stall_s = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- dut ----------------
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
  logic [1:0]    s_stall_cnt, s_bubble_cnt;
  logic          s_up_ready, s_dn_valid;
  logic [DW-1:0] s_dn_data;
  logic [1:0]    s_occ;
`endif

  pipe_stage_skid #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_up_valid(up_valid), .o_up_ready(up_ready), .i_up_data(up_data),
    .o_dn_valid(dn_valid), .i_dn_ready(dn_ready), .o_dn_data(dn_data),
    .o_occ(occ)
`ifdef PIPE_STAGE_PERF_EN
    , .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_skid #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(2)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_up_valid(up_valid), .o_up_ready(s_up_ready), .i_up_data(up_data),
    .o_dn_valid(s_dn_valid), .i_dn_ready(dn_ready), .o_dn_data(s_dn_data),
    .o_occ(s_occ), .o_stall_cnt(s_stall_cnt), .o_bubble_cnt(s_bubble_cnt)
  );
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic uv, input logic [DW-1:0] ud, input logic dr, input logic fl);
    @(posedge clk);
    #1;
    up_valid = uv;
    up_data  = ud;
    dn_ready = dr;
    flush    = fl;
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Samples on the falling edge. Inputs are stable there for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_stall = 0;
      m_bubble = 0;
      m_stall_s = 0;
      chk("rst_occ", occ, 0);
      chk("rst_dn_valid", dn_valid, 0);
      chk("rst_up_ready", up_ready, 1);
      chk("rst_dn_data", dn_data, NOP);
    end else begin
      sz = exp_q.size();
      chk("occ", occ, sz);
      chk("up_ready", up_ready, sz < 2);
      chk("dn_valid", dn_valid, sz > 0);
      chk("dn_data", dn_data, (sz > 0) ? exp_q[0] : NOP);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bubble);
      chk("stall_cnt_sat", s_stall_cnt, m_stall_s);
`endif
      cap = (sz < 2);
      if (sz > 0 && dn_ready) begin
        got = exp_q.pop_front();
        chk("dn_beat", dn_data, got);
        n_beats++;
      end
      if (sz > 0 && !dn_ready) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall_s < 3) m_stall_s++;
      end
      if (sz == 0 && dn_ready && m_bubble < 65535) m_bubble++;
      if (flush) exp_q.delete();
      else if (up_valid && cap) exp_q.push_back(up_data);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset, then a stream of 1..8 at full throughput
    repeat (3) cyc(0, '0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    up_valid = 1'b1; up_data = 16'd1; dn_ready = 1'b1; flush = 1'b0;
    for (int d = 2; d <= 8; d++) cyc(1, DW'(d), 1, 0);
    repeat (2) cyc(0, '0, 1, 0);

    // back-pressure: A, B captured, C held upstream, then drain
    cyc(1, 16'h0A0A, 1, 0);
    cyc(1, 16'h0B0B, 0, 0);
    cyc(1, 16'h0C0C, 0, 0);
    cyc(1, 16'h0C0C, 0, 0);
    cyc(1, 16'h0C0C, 1, 0);
    cyc(1, 16'h0C0C, 1, 0);
    repeat (3) cyc(0, '0, 1, 0);

    // flush while full, with a beat offered in the same cycle
    cyc(1, 16'h0011, 0, 0);
    cyc(1, 16'h0022, 0, 0);
    cyc(1, 16'h0033, 0, 1);
    repeat (3) cyc(0, '0, 1, 0);

    // async reset between clock edges while full
    cyc(1, 16'h0044, 0, 0);
    cyc(1, 16'h0055, 0, 0);
    cyc(0, '0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dn_valid", dn_valid, 0);
    chk("async_rst_occ", occ, 0);
    chk("async_rst_up_ready", up_ready, 1);
    chk("async_rst_dn_data", dn_data, NOP);
`ifdef PIPE_STAGE_PERF_EN
    chk("async_rst_stall_cnt", stall_cnt, 0);
    chk("async_rst_bubble_cnt", bubble_cnt, 0);
`endif
    repeat (2) cyc(0, '0, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // random handshake
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 3) != 0), DW'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end
    repeat (4) cyc(0, '0, 1, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("beats_delivered", (n_beats > 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
